// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared constants, region type and total-length helper for video_timing_gen
// Contents:
//   DEF_*        720p default timing constants
//   region_e     raster region along one axis (active, front porch, sync, back porch)
//   calc_total   total count of one axis from its four region lengths
package video_timing_pkg;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FRONT  = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BACK   = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FRONT  = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BACK   = 20;

  typedef enum logic [1:0] {
    RGN_ACTIVE = 2'd0,
    RGN_FRONT  = 2'd1,
    RGN_SYNC   = 2'd2,
    RGN_BACK   = 2'd3
  } region_e;

  function automatic int calc_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/timing_axis.sv
// rtl/timing_axis.sv - one raster axis counter with region decode
// Ports:
//   clock   in   system clock
//   reset   in   synchronous, active-high reset
//   step    in   advance the counter by one on this clock
//   count   out  W  current counter value, 0..TOTAL-1
//   active  out  counter is in the active region
//   inSync  out  counter is in the sync region
//   wrap    out  this step takes the counter from TOTAL-1 back to 0
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BACK,
  parameter int W      = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         active,
  output logic         inSync,
  output logic         wrap
);

  localparam int TOTAL      = calc_total(ACTIVE, FRONT, SYNC, BACK);
  localparam int SYNC_START = ACTIVE + FRONT;
  localparam int SYNC_END   = SYNC_START + SYNC;
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  if (ACTIVE < 1) begin : g_err_active
    $error("timing_axis: ACTIVE must be non-zero");
  end
  if (SYNC < 1) begin : g_err_sync
    $error("timing_axis: SYNC must be non-zero");
  end
  if (FRONT < 0 || BACK < 0) begin : g_err_porch
    $error("timing_axis: porch lengths must not be negative");
  end
  if ((64'd1 << W) < 64'(TOTAL)) begin : g_err_width
    $error("timing_axis: counter width too small for TOTAL");
  end

  logic [W-1:0] r_count;
  logic [31:0]  w_count32;
  region_e      w_region;

  assign w_count32 = 32'(r_count);

  // Zero-length porches simply make their branch unreachable.
  always_comb begin
    w_region = RGN_BACK;
    if (w_count32 < 32'(ACTIVE)) begin
      w_region = RGN_ACTIVE;
    end else if (w_count32 < 32'(SYNC_START)) begin
      w_region = RGN_FRONT;
    end else if (w_count32 < 32'(SYNC_END)) begin
      w_region = RGN_SYNC;
    end
  end

  assign wrap   = step && (r_count == LAST);
  assign active = (w_region == RGN_ACTIVE);
  assign inSync = (w_region == RGN_SYNC);
  assign count  = r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (step) begin
      r_count <= wrap ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator (DE/HSYNC/VSYNC, pixel coordinates, line/frame strobes)
// Optional feature macro: OVERLAY_WINDOW_EN (adds OVL_* parameters and overlayActive output)
// Ports:
//   clock          in   system clock
//   reset          in   synchronous, active-high reset
//   pixelEnable    in   advance one pixel on this clock
//   DE             out  data enable, high in the active region
//   HSYNC          out  horizontal sync at H_SYNC_POL while asserted
//   VSYNC          out  vertical sync at V_SYNC_POL while asserted, line aligned
//   hPos           out  hBusWidth  horizontal count of the pixel on the outputs
//   vPos           out  vBusWidth  vertical count of the pixel on the outputs
//   lineStart      out  one-clock pulse when the outputs show hPos=0
//   overlayActive  out  (OVERLAY_WINDOW_EN) outputs show a pixel inside the overlay window
//   frameStart     out  one-clock pulse when the outputs show hPos=0, vPos=0
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FRONT    = DEF_H_FRONT,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BACK     = DEF_H_BACK,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FRONT    = DEF_V_FRONT,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BACK     = DEF_V_BACK,
  parameter logic H_SYNC_POL = 1'b1,
  parameter logic V_SYNC_POL = 1'b1,
`ifdef OVERLAY_WINDOW_EN
  parameter int   OVL_X      = 0,
  parameter int   OVL_Y      = 0,
  parameter int   OVL_W      = 320,
  parameter int   OVL_H      = 240,
`endif
  parameter int   hBusWidth  = 12,
  parameter int   vBusWidth  = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pixelEnable,
  output logic                 DE,
  output logic                 HSYNC,
  output logic                 VSYNC,
  output logic [hBusWidth-1:0] hPos,
  output logic [vBusWidth-1:0] vPos,
  output logic                 lineStart,
`ifdef OVERLAY_WINDOW_EN
  output logic                 overlayActive,
`endif
  output logic                 frameStart
);

  logic [hBusWidth-1:0] w_hcount;
  logic [vBusWidth-1:0] w_vcount;
  logic w_h_active, w_h_in_sync, w_h_wrap;
  logic w_v_active, w_v_in_sync, w_v_wrap;

  timing_axis #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(hBusWidth)
  ) u_h_axis (
    .clock (clock),
    .reset (reset),
    .step  (pixelEnable),
    .count (w_hcount),
    .active(w_h_active),
    .inSync(w_h_in_sync),
    .wrap  (w_h_wrap)
  );

  // The vertical axis only moves when a line completes, so its region
  // decode is constant across a line and VSYNC is line aligned.
  timing_axis #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(vBusWidth)
  ) u_v_axis (
    .clock (clock),
    .reset (reset),
    .step  (w_h_wrap),
    .count (w_vcount),
    .active(w_v_active),
    .inSync(w_v_in_sync),
    .wrap  (w_v_wrap)
  );

  logic                 r_de, r_hsync, r_vsync, r_line_start, r_frame_start;
  logic                 r_frame_armed;
  logic [hBusWidth-1:0] r_hpos;
  logic [vBusWidth-1:0] r_vpos;

`ifdef OVERLAY_WINDOW_EN
  logic               r_ovl;
  logic               w_ovl_hit;
  logic signed [31:0] w_ovl_dx, w_ovl_dy;

  // Gated by DE below, which clips the window to the active area.
  always_comb begin
    w_ovl_dx  = $signed(32'(w_hcount)) - OVL_X;
    w_ovl_dy  = $signed(32'(w_vcount)) - OVL_Y;
    w_ovl_hit = (w_ovl_dx >= 0) && (w_ovl_dx < OVL_W) &&
                (w_ovl_dy >= 0) && (w_ovl_dy < OVL_H);
  end

  assign overlayActive = r_ovl;
`endif

  // r_frame_armed marks that the counters sit at (0,0): set by reset and by
  // the step that wraps the whole frame, consumed by the next enabled step.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_de          <= 1'b0;
      r_hsync       <= ~H_SYNC_POL;
      r_vsync       <= ~V_SYNC_POL;
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_armed <= 1'b1;
`ifdef OVERLAY_WINDOW_EN
      r_ovl         <= 1'b0;
`endif
    end else if (pixelEnable) begin
      r_de          <= w_h_active & w_v_active;
      r_hsync       <= w_h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
      r_vsync       <= w_v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
      r_hpos        <= w_hcount;
      r_vpos        <= w_vcount;
      r_line_start  <= (w_hcount == '0);
      r_frame_start <= r_frame_armed;
      r_frame_armed <= w_v_wrap;
`ifdef OVERLAY_WINDOW_EN
      r_ovl         <= w_h_active & w_v_active & w_ovl_hit;
`endif
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign DE         = r_de;
  assign HSYNC      = r_hsync;
  assign VSYNC      = r_vsync;
  assign hPos       = r_hpos;
  assign vPos       = r_vpos;
  assign lineStart  = r_line_start;
  assign frameStart = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen on a small raster
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int OX = 2, OY = 1, OW = 3, OH = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pixelEnable = 1'b0;
  logic       de_p, hs_p, vs_p, ls_p, fs_p;
  logic [3:0] hpos_p;
  logic [2:0] vpos_p;
  logic       de_n, hs_n, vs_n, ls_n, fs_n;
  logic [3:0] hpos_n;
  logic [2:0] vpos_n;
  logic       ovl_p, ovl_n;

  always #5 clock = ~clock;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
`ifdef OVERLAY_WINDOW_EN
    .OVL_X(OX), .OVL_Y(OY), .OVL_W(OW), .OVL_H(OH),
`endif
    .hBusWidth(4), .vBusWidth(3)
  ) u_dut (
    .clock(clock), .reset(reset), .pixelEnable(pixelEnable),
    .DE(de_p), .HSYNC(hs_p), .VSYNC(vs_p), .hPos(hpos_p), .vPos(vpos_p),
    .lineStart(ls_p),
`ifdef OVERLAY_WINDOW_EN
    .overlayActive(ovl_p),
`endif
    .frameStart(fs_p)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
`ifdef OVERLAY_WINDOW_EN
    .OVL_X(OX), .OVL_Y(OY), .OVL_W(OW), .OVL_H(OH),
`endif
    .hBusWidth(4), .vBusWidth(3)
  ) u_dut_n (
    .clock(clock), .reset(reset), .pixelEnable(pixelEnable),
    .DE(de_n), .HSYNC(hs_n), .VSYNC(vs_n), .hPos(hpos_n), .vPos(vpos_n),
    .lineStart(ls_n),
`ifdef OVERLAY_WINDOW_EN
    .overlayActive(ovl_n),
`endif
    .frameStart(fs_n)
  );

`ifndef OVERLAY_WINDOW_EN
  assign ovl_p = 1'b0;
  assign ovl_n = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: k is the linear pixel index of the counters; the
  // outputs after an enabled edge describe pixel k before it advances.
  int   k = 0;
  int   cyc = 0;
  logic e_de = 0, e_hsa = 0, e_vsa = 0, e_ls = 0, e_fs = 0, e_ovl = 0;
  int   e_h = 0, e_v = 0;
  int   exp_period = 0;
  int   last_fs = -1;
  int   ovl_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_edge(input logic pe, input logic rst);
    int h, v;
    pixelEnable = pe;
    reset       = rst;
    @(posedge clock);
    #1;
    cyc++;
    if (rst) begin
      k = 0;
      e_de = 0; e_hsa = 0; e_vsa = 0; e_ls = 0; e_fs = 0; e_ovl = 0;
      e_h = 0; e_v = 0;
      last_fs = -1;
      ovl_cnt = 0;
    end else if (pe) begin
      h = k % HT;
      v = k / HT;
      e_de  = (h < HA) && (v < VA);
      e_hsa = (h >= HA + HF) && (h < HA + HF + HS);
      e_vsa = (v >= VA + VF) && (v < VA + VF + VS);
      e_h   = h;
      e_v   = v;
      e_ls  = (h == 0);
      e_fs  = (k == 0);
`ifdef OVERLAY_WINDOW_EN
      e_ovl = e_de && (h >= OX) && (h < OX + OW) && (v >= OY) && (v < OY + OH);
`else
      e_ovl = 1'b0;
`endif
      k = (k + 1) % FT;
    end else begin
      e_ls = 0;
      e_fs = 0;
    end

    chk("de", de_p, e_de);
    chk("hsync", hs_p, e_hsa);
    chk("vsync", vs_p, e_vsa);
    chk("hpos", hpos_p, e_h);
    chk("vpos", vpos_p, e_v);
    chk("line_start", ls_p, e_ls);
    chk("frame_start", fs_p, e_fs);
    chk("overlay", ovl_p, e_ovl);
    chk("de_neg", de_n, e_de);
    chk("hsync_neg", hs_n, !e_hsa);
    chk("vsync_neg", vs_n, !e_vsa);
    chk("fs_neg", fs_n, e_fs);

    if (!rst) begin
      if (fs_p === 1'b1) begin
        if (last_fs >= 0 && exp_period != 0) begin
          chk("frame_period", cyc - last_fs, exp_period);
`ifdef OVERLAY_WINDOW_EN
          chk("ovl_per_frame", ovl_cnt, OW * OH);
`endif
        end
        last_fs = cyc;
        ovl_cnt = 0;
      end
      if (pe && ovl_p === 1'b1) ovl_cnt++;
    end
  endtask

  initial begin
    // Reset held with random pixelEnable: outputs idle, syncs inactive.
    for (int i = 0; i < 3; i++) do_edge(1'($urandom_range(0, 1)), 1'b1);

    // Continuous enable: first edge shows (0,0) with both strobes; 98-clock frames.
    exp_period = FT;
    do_edge(1'b1, 1'b0);
    chk("first_de", de_p, 1'b1);
    chk("first_fs", fs_p, 1'b1);
    chk("first_ls", ls_p, 1'b1);
    for (int i = 0; i < 3 * FT; i++) do_edge(1'b1, 1'b0);

    // Alternating enable doubles the frame period.
    exp_period = 2 * FT;
    last_fs = -1;
    for (int i = 0; i < 3 * FT; i++) begin
      do_edge(1'b1, 1'b0);
      do_edge(1'b0, 1'b0);
    end

    // Reset mid-frame at (5,2), then restart from (0,0).
    exp_period = FT;
    do_edge(1'b1, 1'b1);
    for (int i = 0; i < 2 * HT + 6; i++) do_edge(1'b1, 1'b0);
    chk("mid_hpos", hpos_p, 5);
    chk("mid_vpos", vpos_p, 2);
    do_edge(1'b0, 1'b1);
    chk("rst_de", de_p, 1'b0);
    chk("rst_hpos", hpos_p, 0);
    do_edge(1'b1, 1'b0);
    chk("restart_fs", fs_p, 1'b1);
    chk("restart_vpos", vpos_p, 0);

    // Random enable with occasional reset.
    exp_period = 0;
    for (int i = 0; i < 3000; i++) begin
      do_edge(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator producing DE, HSYNC and VSYNC for the HDMI transmitter, plus pixel coordinates and frame/line strobes for the overlay pixel pipeline. It generalises the fixed 1280x720 counter pair into a full timing engine with configurable porches, sync widths and sync polarities, and a pixel-clock-enable input for slower pixel rates. It sits between the system clock domain and the overlay compositor and transmitter.

## Interface
- H_ACTIVE, 1280, visible pixels per line
- H_FRONT, 110, horizontal front porch (pixels)
- H_SYNC, 40, HSYNC width (pixels)
- H_BACK, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, visible lines per frame
- V_FRONT, 5, vertical front porch (lines)
- V_SYNC, 5, VSYNC width (lines)
- V_BACK, 20, vertical back porch (lines)
- H_SYNC_POL, 1, HSYNC active level
- V_SYNC_POL, 1, VSYNC active level
- hBusWidth, 12, horizontal counter width; must satisfy 2^hBusWidth >= H_TOTAL
- vBusWidth, 12, vertical counter width; must satisfy 2^vBusWidth >= V_TOTAL
- clock  in  1  system clock; sole clock
- reset  in  1  synchronous, active-high reset
- pixelEnable  in  1  advance one pixel on this clock when high
- DE  out  1  data enable, high in active region
- HSYNC  out  1  horizontal sync, level per H_SYNC_POL
- VSYNC  out  1  vertical sync, level per V_SYNC_POL
- hPos  out  hBusWidth  horizontal count of the current output pixel
- vPos  out  vBusWidth  vertical count of the current output pixel
- lineStart  out  1  one-clock pulse when outputs show hPos=0
- frameStart  out  1  one-clock pulse when outputs show hPos=0, vPos=0

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (1650 default); V_TOTAL likewise (750).
- hCount runs 0..H_TOTAL-1, incrementing on each clock with pixelEnable=1; wraps to 0 after H_TOTAL-1.
- vCount increments only on the hCount wrap; wraps to 0 after V_TOTAL-1 on the same cycle hCount wraps.
- Region order per axis: active [0, ACTIVE), front porch, sync [ACTIVE+FRONT, ACTIVE+FRONT+SYNC), back porch.
- DE = hActive AND vActive. HSYNC = H_SYNC_POL when hCount in sync region, else inverse. VSYNC changes only at hCount=0 (line-aligned), V_SYNC_POL during vertical sync lines.
- pixelEnable=0: counters and DE/HSYNC/VSYNC/hPos/vPos hold; lineStart/frameStart forced 0.
- Zero-width porch parameters are legal; zero ACTIVE or SYNC is an elaboration error, as is an undersized bus width.

## Timing
- All outputs registered; outputs reflect counter state one clock after the enabled edge that produced it (latency 1).
- Reset values: counters 0; DE=0, HSYNC=!H_SYNC_POL, VSYNC=!V_SYNC_POL, hPos=0, vPos=0, lineStart=0, frameStart=0.
- First clock with pixelEnable=1 after reset deassertion registers counter (0,0): DE=1, frameStart=1, lineStart=1 on that edge.
- Reset asserted mid-frame: all state returns to reset values on the next edge regardless of pixelEnable; reset has priority.
- Strobes are exactly one clock wide even when pixelEnable stays high.

## Configuration
- OVERLAY_WINDOW_EN: when defined, adds parameters OVL_X (0), OVL_Y (0), OVL_W (320), OVL_H (240) and output overlayActive (1 bit, registered, reset 0), high when DE=1 and OVL_X<=hPos<OVL_X+OVL_W and OVL_Y<=vPos<OVL_Y+OVL_H; window clipped to the active area. When undefined, neither the port nor the parameters exist.

## Structure
- Package video_timing_pkg: 720p default constants, H_TOTAL/V_TOTAL derivation function, region enumeration (ACTIVE, FRONT, SYNC, BACK).
- Sub-module timing_axis, instanced twice (horizontal, vertical): parameters ACTIVE/FRONT/SYNC/BACK/width, inputs clock, reset, step; outputs count, active, inSync, wrap.

## Test plan
- Small config H 8/2/2/2, V 4/1/1/1, pixelEnable=1: DE high 8 clocks of every 14, for 4 lines of 7; HSYNC active at hPos 10-11; frameStart period 98 clocks.
- Release reset with pixelEnable=1: first edge gives DE=1, frameStart=1, lineStart=1, hPos=0, vPos=0; during reset HSYNC=VSYNC=inactive.
- pixelEnable toggling 1/0 per clock: frame period doubles to 196 clocks, strobes stay one clock wide, outputs hold on disabled clocks.
- H_SYNC_POL=0, V_SYNC_POL=0: sync outputs idle high, low at hPos 10-11 and vPos 5 respectively.
- Assert reset at hPos=5, vPos=2: next edge all outputs at reset values; counting restarts from (0,0).
- OVERLAY_WINDOW_EN, OVL 2,1,3,2: overlayActive high only at hPos 2-4 on vPos 1-2, 6 clocks per frame.
